// File: rtl/render_scheduler.sv
// -----------------------------------------------------------------------------
// render_scheduler
//
// Sequences the memory-dump renderer. For each render it holds the renderer in
// reset for ARM_CYCLES cycles, issues a one-cycle start strobe with the selected
// page byte address, and then owns the data-memory read port until the renderer
// reports done or the watchdog expires. CPU reads stall while the renderer owns
// the port.
//
// Optional feature (compile-time macro):
//   RENDER_AUTO_REFRESH_EN - when defined, a free-running refresh timer
//                            re-renders the current page every REFRESH_CYCLES
//                            cycles of IDLE/RENDER time.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-low reset
//   page_up         in   pulse: advance one page
//   page_down       in   pulse: go back one page
//   refresh_req     in   pulse: re-render current page
//   cpu_mem_req     in   CPU wants the read port this cycle
//   cpu_mem_addr    in   CPU word address [15:0]
//   rend_mem_addr   in   renderer word address [15:0]
//   rend_done       in   renderer finished (level)
//   rend_rst        out  active-low renderer reset
//   rend_start      out  renderer start strobe
//   rend_start_addr out  byte start address of the render [17:0]
//   mem_addr        out  word address to data memory [15:0]
//   cpu_stall       out  CPU read denied this cycle
//   busy            out  scheduler not idle
//   timeout_err     out  sticky: a render timed out
//   frame_count     out  completed renders, wrapping [15:0]
// -----------------------------------------------------------------------------
module render_scheduler #(
    parameter int PAGE_BYTES     = 928,
    parameter int ADDR_LIMIT     = 262144,
    parameter int ARM_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16384,
    parameter int REFRESH_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        page_up,
    input  logic        page_down,
    input  logic        refresh_req,
    input  logic        cpu_mem_req,
    input  logic [15:0] cpu_mem_addr,
    input  logic [15:0] rend_mem_addr,
    input  logic        rend_done,
    output logic        rend_rst,
    output logic        rend_start,
    output logic [17:0] rend_start_addr,
    output logic [15:0] mem_addr,
    output logic        cpu_stall,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] frame_count
);

    localparam int ARM_W = $clog2(ARM_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_KICK   = 2'd2,
        S_RENDER = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [17:0]       page_addr_q, page_addr_d;
    logic [17:0]       start_addr_q, start_addr_d;
    logic              pend_q, pend_d;
    logic              timeout_err_q, timeout_err_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic              arm_last;
    logic              wd_last;
    logic              step_up;
    logic              step_dn;
    logic              req;
    logic              refresh_fire;

    // Page stepping modulo ADDR_LIMIT; page_addr is always below ADDR_LIMIT.
    function automatic logic [17:0] page_inc(input logic [17:0] a);
        logic [18:0] s;
        s = {1'b0, a} + 19'(PAGE_BYTES);
        if (s >= 19'(ADDR_LIMIT)) begin
            s = s - 19'(ADDR_LIMIT);
        end
        return s[17:0];
    endfunction

    function automatic logic [17:0] page_dec(input logic [17:0] a);
        logic [18:0] s;
        if (a >= 18'(PAGE_BYTES)) begin
            s = {1'b0, a} - 19'(PAGE_BYTES);
        end else begin
            s = {1'b0, a} + 19'(ADDR_LIMIT) - 19'(PAGE_BYTES);
        end
        return s[17:0];
    endfunction

    assign arm_last = (arm_cnt_q == ARM_W'(ARM_CYCLES - 1));
    assign wd_last  = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Opposing steps in the same cycle cancel and do not request a render.
    assign step_up = page_up & ~page_down;
    assign step_dn = page_down & ~page_up;
    assign req     = step_up | step_dn | refresh_req;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (arm_last) begin
                    state_d = S_KICK;
                end
            end
            S_KICK: begin
                state_d = S_RENDER;
            end
            S_RENDER: begin
                // Done wins over a watchdog expiry in the same cycle.
                if (rend_done || wd_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // Renderer is held in reset while our own reset is asserted as well.
        rend_rst   = rst & (state_q != S_ARM);
        rend_start = (state_q == S_KICK);
        busy       = (state_q != S_IDLE);
        if (state_q == S_RENDER) begin
            mem_addr  = rend_mem_addr;
            cpu_stall = cpu_mem_req;
        end else begin
            mem_addr  = cpu_mem_addr;
            cpu_stall = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Optional auto-refresh timer
    // -------------------------------------------------------------------------
`ifdef RENDER_AUTO_REFRESH_EN
    logic [25:0] refresh_cnt_q, refresh_cnt_d;
    logic        timer_run;

    // Runs only in IDLE/RENDER and only while no render is already pending.
    assign timer_run    = ~pend_q & ((state_q == S_IDLE) | (state_q == S_RENDER));
    assign refresh_fire = timer_run & (refresh_cnt_q == 26'(REFRESH_CYCLES - 1));

    always_comb begin
        refresh_cnt_d = refresh_cnt_q;
        if (pend_q) begin
            refresh_cnt_d = '0;
        end else if (timer_run) begin
            refresh_cnt_d = refresh_fire ? '0 : refresh_cnt_q + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt_q <= '0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
        end
    end
`else
    assign refresh_fire = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Datapath / bookkeeping next-state
    // -------------------------------------------------------------------------
    always_comb begin
        arm_cnt_d     = '0;
        wd_d          = wd_q;
        page_addr_d   = page_addr_q;
        start_addr_d  = start_addr_q;
        pend_d        = pend_q;
        timeout_err_d = timeout_err_q;
        frame_count_d = frame_count_q;

        if (state_q == S_ARM) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end

        if (state_q == S_KICK) begin
            wd_d = '0;
        end else if (state_q == S_RENDER) begin
            wd_d = wd_q + WD_W'(1);
        end

        if (step_up) begin
            page_addr_d = page_inc(page_addr_q);
        end else if (step_dn) begin
            page_addr_d = page_dec(page_addr_q);
        end

        // Launch takes the current page; a request in the same cycle re-arms
        // pend below so it is serviced by a following render.
        if (state_q == S_IDLE && pend_q) begin
            start_addr_d = page_addr_q;
            pend_d       = 1'b0;
        end
        if (req || refresh_fire) begin
            pend_d = 1'b1;
        end

        if (state_q == S_RENDER) begin
            if (rend_done) begin
                frame_count_d = frame_count_q + 16'd1;
            end else if (wd_last) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_cnt_q     <= '0;
            wd_q          <= '0;
            page_addr_q   <= '0;
            start_addr_q  <= '0;
            pend_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            arm_cnt_q     <= arm_cnt_d;
            wd_q          <= wd_d;
            page_addr_q   <= page_addr_d;
            start_addr_q  <= start_addr_d;
            pend_q        <= pend_d;
            timeout_err_q <= timeout_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign rend_start_addr = start_addr_q;
    assign timeout_err     = timeout_err_q;
    assign frame_count     = frame_count_q;

endmodule
